// File: rtl/lookup_ctrl_writer_pkg.sv
// Shared constants, header layout and FSM encoding for the control-channel writer.
package lookup_ctrl_writer_pkg;

  localparam int unsigned DATA_W      = 256;
  localparam int unsigned KEEP_W      = DATA_W / 8;
  localparam int unsigned KEY_W       = 1024;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned ERR_W       = 16;

  localparam int unsigned HDR_ID_W    = 5;
  localparam int unsigned HDR_RES_W   = 3;
  localparam int unsigned HDR_IDX_W   = 4;
  localparam int unsigned HDR_W       = HDR_ID_W + HDR_RES_W + HDR_IDX_W;

  localparam logic [HDR_RES_W-1:0] RES_TCAM = 3'd1;
  localparam logic [HDR_RES_W-1:0] RES_ACT  = 3'd2;

  localparam int unsigned TCAM_BEATS  = 8;
  localparam int unsigned ACT_BEATS   = 3;
  localparam int unsigned BEAT_CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TCAM_S = 2'd1,
    ACT_S  = 2'd2,
    DROP_S = 2'd3
  } state_e;

  // One stream beat as held in the forward slice
  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
  } axis_beat_t;

  // Header fields in beat 0, LSB first: module_id, resource, index
  typedef struct packed {
    logic [HDR_IDX_W-1:0] index;
    logic [HDR_RES_W-1:0] resource;
    logic [HDR_ID_W-1:0]  module_id;
  } ctrl_hdr_t;

  function automatic ctrl_hdr_t hdr_decode(input logic [HDR_W-1:0] bits);
    return ctrl_hdr_t'(bits);
  endfunction

endpackage

// File: rtl/lookup_ctrl_writer_if.sv
// 256-bit control AXI-Stream bundle.
interface lookup_ctrl_writer_if;
  import lookup_ctrl_writer_pkg::*;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/lookup_ctrl_writer_reg_slice.sv
// One-deep forward register slice; upstream ready while the slot is empty or draining.
module ctrl_axis_reg_slice
  import lookup_ctrl_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  lookup_ctrl_writer_if.slave   s,
  lookup_ctrl_writer_if.master  m
);

  axis_beat_t beat_q;
  logic       valid_q;

  assign s.tready = m.tready || !valid_q;

  assign m.tdata  = beat_q.tdata;
  assign m.tkeep  = beat_q.tkeep;
  assign m.tlast  = beat_q.tlast;
  assign m.tvalid = valid_q;

  // Capture on upstream accept, empty once downstream takes the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else if (s.tvalid && s.tready) begin
      beat_q.tdata <= s.tdata;
      beat_q.tkeep <= s.tkeep;
      beat_q.tlast <= s.tlast;
      valid_q      <= 1'b1;
    end else if (m.tready) begin
      valid_q      <= 1'b0;
    end
  end

endmodule

// File: rtl/lookup_ctrl_writer.sv
// Control-packet parser: assembles TCAM / action writes and forwards the stream.
module lookup_ctrl_writer
  import lookup_ctrl_writer_pkg::*;
#(
  parameter int unsigned STAGE        = 0,
  parameter int unsigned ACT_LEN      = 25,
  parameter int unsigned C_DATA_WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lookup_ctrl_writer_if.slave      ctrl_s_axis,
  lookup_ctrl_writer_if.master     ctrl_m_axis,
  output logic [KEY_W-1:0]         lookup_din,
  output logic [KEY_W-1:0]         lookup_din_mask,
  output logic [ADDR_W-1:0]        lookup_din_addr,
  output logic                     lookup_din_en,
  output logic [ACT_LEN*25-1:0]    action_data_in,
  output logic [ADDR_W-1:0]        action_addr,
  output logic                     action_en,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int unsigned ACT_W = ACT_LEN * 25;
  localparam int unsigned ASM_W = 2 * KEY_W;

  state_e                 state_q, state_d;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]      index_q, index_d;
  logic [ASM_W-1:0]       asm_q, asm_d;

  logic                   accept_c;
  ctrl_hdr_t              hdr_c;
  logic                   own_c;
  logic                   known_res_c;
  logic                   last_beat_c;
  logic                   tcam_wr_c;
  logic                   act_wr_c;
  logic                   err_inc_c;

  ctrl_axis_reg_slice u_slice (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (ctrl_s_axis),
    .m     (ctrl_m_axis)
  );

  assign accept_c    = ctrl_s_axis.tvalid && ctrl_s_axis.tready;
  assign hdr_c       = hdr_decode(ctrl_s_axis.tdata[HDR_W-1:0]);
  assign own_c       = (hdr_c.module_id == HDR_ID_W'(STAGE));
  assign known_res_c = (hdr_c.resource == RES_TCAM) || (hdr_c.resource == RES_ACT);
  assign last_beat_c = (state_q == TCAM_S) ? (beat_cnt_q == BEAT_CNT_W'(TCAM_BEATS - 1))
                                           : (beat_cnt_q == BEAT_CNT_W'(ACT_BEATS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: advance only on accepted beats
  always_comb begin
    state_d = state_q;
    if (accept_c) begin
      case (state_q)
        IDLE: begin
          if (!ctrl_s_axis.tlast) begin
            if (own_c && hdr_c.resource == RES_TCAM)     state_d = TCAM_S;
            else if (own_c && hdr_c.resource == RES_ACT) state_d = ACT_S;
            else                                         state_d = DROP_S;
          end
        end
        TCAM_S, ACT_S: begin
          if (ctrl_s_axis.tlast)  state_d = IDLE;
          else if (last_beat_c)   state_d = DROP_S;
        end
        DROP_S: begin
          if (ctrl_s_axis.tlast)  state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: payload assembly, write commit and error decisions
  always_comb begin
    tcam_wr_c  = 1'b0;
    act_wr_c   = 1'b0;
    err_inc_c  = 1'b0;
    beat_cnt_d = beat_cnt_q;
    index_d    = index_q;
    asm_d      = asm_q;
    if (accept_c) begin
      case (state_q)
        IDLE: begin
          beat_cnt_d = '0;
          index_d    = hdr_c.index;
          err_inc_c  = ctrl_s_axis.tlast && own_c && known_res_c;
        end
        TCAM_S, ACT_S: begin
          asm_d[int'(beat_cnt_q) * C_DATA_WIDTH +: C_DATA_WIDTH] = ctrl_s_axis.tdata;
          beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
          if (ctrl_s_axis.tlast && last_beat_c) begin
            tcam_wr_c = (state_q == TCAM_S);
            act_wr_c  = (state_q == ACT_S);
          end else if (ctrl_s_axis.tlast || last_beat_c) begin
            err_inc_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Assembly buffer and header index; a reset drops any partial packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      index_q    <= '0;
      asm_q      <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      index_q    <= index_d;
      asm_q      <= asm_d;
    end
  end

  // Write ports: one-cycle strobes, data/addr held until the next write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_din      <= '0;
      lookup_din_mask <= '0;
      lookup_din_addr <= '0;
      lookup_din_en   <= 1'b0;
      action_data_in  <= '0;
      action_addr     <= '0;
      action_en       <= 1'b0;
      err_cnt         <= '0;
    end else begin
      lookup_din_en <= tcam_wr_c;
      action_en     <= act_wr_c;
      if (tcam_wr_c) begin
        lookup_din      <= asm_d[KEY_W-1:0];
        lookup_din_mask <= asm_d[ASM_W-1:KEY_W];
        lookup_din_addr <= index_q;
      end
      if (act_wr_c) begin
        action_data_in  <= asm_d[ACT_W-1:0];
        action_addr     <= index_q;
      end
      if (err_inc_c && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule
